// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request found scanning upward from rr_ptr+1.
module uart_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    int cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!found_o && req_i[IDX_W'(cand)]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter merging NUM_REQ FWFT transmit FIFOs into one FWFT port
// for uart_state, with bounded bursts per grant.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                      clock_125,
    input  logic                      rst_125,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_empty,
    output logic [NUM_REQ-1:0]        req_rden,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      uart_txfifo_empty,
    input  logic                      uart_txfifo_rden,
    output logic [DATA_W-1:0]         uart_txfifo_data,
    output logic                      grant_vld,
    output logic [IDX_W-1:0]          grant_id
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             head_empty;
    logic             pop;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (~req_empty),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge clock_125) begin
        if (rst_125) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign head_empty = req_empty[grant_id_q];
    // Pops are forwarded only to a non-empty granted FIFO; anything else is dropped.
    assign pop        = (state_q == GRANT) && uart_txfifo_rden && !head_empty;

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_id_d        = grant_id_q;
        burst_cnt_d       = burst_cnt_q;
        req_rden          = '0;
        uart_txfifo_empty = 1'b1;
        uart_txfifo_data  = '0;
        grant_vld         = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_en && pick_found) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                grant_vld            = 1'b1;
                uart_txfifo_empty    = head_empty;
                uart_txfifo_data     = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
                req_rden[grant_id_q] = pop;
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = RELEASE;
                    end
                end else if (head_empty || !arb_en) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                rr_ptr_d = grant_id_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_id_q;

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that lets several word-producing clients share the single UART transmit path. It sits between NUM_REQ first-word-fall-through (FWFT) transmit FIFOs and the transmit-FIFO port of the UART state machine (`uart_state`). To `uart_state` it looks like one FWFT FIFO. It grants one requester at a time for a bounded burst, then rotates priority.

## Interface
Parameters:
- NUM_REQ, 4: number of requester FIFOs (2..8).
- DATA_W, 32: word width, matching the UART transmit-FIFO word.
- MAX_BURST, 16: maximum words popped per grant (1..255).

Ports:
- clock_125  in  1  system clock; one clock domain.
- rst_125  in  1  synchronous, active-high reset.
- arb_en  in  1  arbitration enable; 0 blocks new grants.
- req_empty  in  NUM_REQ  per-requester FIFO empty flag.
- req_rden  out  NUM_REQ  per-requester pop strobe; one-hot or zero.
- req_data  in  NUM_REQ*DATA_W  FWFT head words; requester i occupies bits [i*DATA_W +: DATA_W].
- uart_txfifo_empty  out  1  merged empty flag toward `uart_state`.
- uart_txfifo_rden  in  1  pop strobe from `uart_state`.
- uart_txfifo_data  out  DATA_W  head word of the granted requester.
- grant_vld  out  1  a requester currently holds the grant.
- grant_id  out  $clog2(NUM_REQ)  index of the granted requester.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE
  - If arb_en=1 and any req_empty bit is 0, pick the first non-empty requester scanning upward from rr_ptr+1 (modulo NUM_REQ).
  - Register that index into grant_id, clear burst_cnt, go to GRANT.
- GRANT
  - grant_vld=1.
  - uart_txfifo_empty = req_empty[grant_id].
  - uart_txfifo_data = req_data[grant_id].
  - req_rden[grant_id] = uart_txfifo_rden & ~req_empty[grant_id]; all other req_rden bits are 0.
  - Each forwarded pop increments burst_cnt.
- Exit from GRANT to RELEASE on any of:
  - a forwarded pop that makes burst_cnt reach MAX_BURST;
  - req_empty[grant_id]=1 in a cycle with no forwarded pop;
  - arb_en=0 in a cycle with no forwarded pop.
- RELEASE
  - Lasts one cycle: uart_txfifo_empty=1, grant_vld=0, no pops.
  - Sets rr_ptr to grant_id, then goes to IDLE.
- Outside GRANT: uart_txfifo_empty=1, uart_txfifo_data=0, req_rden=0.
- uart_txfifo_rden while uart_txfifo_empty=1: ignored, nothing is forwarded.
- burst_cnt is $clog2(MAX_BURST+1) bits and never wraps, because the grant ends at MAX_BURST.
- rr_ptr is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ.

## Timing
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 wins first), grant_id=0, grant_vld=0, burst_cnt=0, req_rden=0, uart_txfifo_empty=1, uart_txfifo_data=0.
- Grant latency: requester non-empty in IDLE at cycle N → grant_vld=1 and uart_txfifo_empty low at N+1.
- Pop path is combinational, zero latency: uart_txfifo_rden → req_rden in the same cycle.
- Handover gap: at least 2 idle cycles between the last pop of one grant and the first possible pop of the next (RELEASE plus IDLE).
- A requester that empties at the same moment as MAX_BURST is reached: MAX_BURST takes effect and the pop is forwarded.
- arb_en falling during a pop cycle: the pop completes; RELEASE follows in the next no-pop cycle.
- Reset asserted mid-burst: all state returns to reset values on the next clock edge. Pops in that cycle are still forwarded combinationally, so the data source must be reset together with the arbiter.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE/GRANT/RELEASE) and default parameter constants.
- Sub-module `uart_rr_pick`: combinational rotate-priority picker. Inputs are the request vector and rr_ptr; outputs are found and index.
- Top level holds the FSM, counters, data mux and rden demux.

## Test plan
- Single requester: requester 2 holds 3 words; sink pops every cycle. Expected: 3 pops on req_rden[2], data in order, then RELEASE; the next grant search starts from requester 3.
- Burst cap: MAX_BURST=4, requester 0 holds 10 words, requester 1 holds 2 words. Expected grant order: 0 (4 words), 1 (2 words), 0 (4 words), 0 (2 words).
- Fairness: all four requesters always non-empty, MAX_BURST=1. Expected grant_id sequence 0,1,2,3,0 with a 2-cycle gap between grants.
- Pop while empty: assert uart_txfifo_rden in IDLE and in RELEASE. Expected: req_rden stays 0 and no state change.
- arb_en drop: clear arb_en during a pop in the middle of a 5-word burst. Expected: that pop completes, RELEASE follows, no new grant until arb_en=1.
- Reset mid-burst: assert rst_125 after the 2nd pop. Expected: next cycle grant_vld=0 and uart_txfifo_empty=1; the first grant after reset goes to requester 0.
